// File: rtl/uart_rx_frame.sv
// uart_rx_frame: serial receive framer behind a baud-rate generator.
// Mid-bit start check, tick-driven data/parity/stop sampling, 1-cycle valid.
module uart_rx_frame #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 areset_n,
  input  logic                 rx,
  input  logic [31:0]          divisor,
  input  logic                 baud_tick,
  output logic                 baud_start,
  output logic [DATA_BITS-1:0] data,
  output logic                 data_valid,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START_CHK,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_DONE
  } state_t;

  localparam logic PODD = (PARITY_ODD != 0);

  state_t               r_state;
  logic                 r_rx_m;
  logic                 r_rx_s;
  logic                 r_rx_d;
  logic [31:0]          r_half_cnt;
  logic [3:0]           r_bit_idx;
  logic [1:0]           r_stop_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_fe_pend;
  logic                 r_pe_pend;
  logic                 r_baud_start;
  logic                 r_busy;
  logic                 r_valid;
  logic                 r_fe;
  logic                 r_pe;
  logic [DATA_BITS-1:0] r_data;

  logic w_fall;
  logic w_half_hit;
  logic w_tick;
  logic w_last_data;
  logic w_last_stop;
  logic w_par_calc;

  assign w_fall      = r_rx_d & ~r_rx_s;
  assign w_half_hit  = (r_half_cnt == (divisor >> 1));
  assign w_tick      = baud_tick & r_baud_start;
  assign w_last_data = (r_bit_idx == 4'(DATA_BITS - 1));
  assign w_last_stop = (r_stop_idx == 2'(STOP_BITS - 1));
  assign w_par_calc  = (^r_shift) ^ r_rx_s ^ PODD;

  assign baud_start = r_baud_start;
  assign data       = r_data;
  assign data_valid = r_valid;
  assign frame_err  = r_fe;
  assign parity_err = r_pe;
  assign busy       = r_busy;

  // two-flop synchroniser plus one delay flop for falling-edge detection
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      r_rx_m <= 1'b1;
      r_rx_s <= 1'b1;
      r_rx_d <= 1'b1;
    end else begin
      r_rx_m <= rx;
      r_rx_s <= r_rx_m;
      r_rx_d <= r_rx_s;
    end
  end

  // frame sequencer with registered outputs
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      r_state      <= S_IDLE;
      r_half_cnt   <= '0;
      r_bit_idx    <= '0;
      r_stop_idx   <= '0;
      r_shift      <= '0;
      r_fe_pend    <= 1'b0;
      r_pe_pend    <= 1'b0;
      r_baud_start <= 1'b0;
      r_busy       <= 1'b0;
      r_valid      <= 1'b0;
      r_fe         <= 1'b0;
      r_pe         <= 1'b0;
      r_data       <= '0;
    end else begin
      r_valid <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_fall) begin
            r_state    <= S_START_CHK;
            r_half_cnt <= '0;
            r_busy     <= 1'b1;
          end
        end
        S_START_CHK: begin
          r_half_cnt <= r_half_cnt + 32'd1;
          if (w_half_hit) begin
            if (!r_rx_s) begin
              r_state      <= S_DATA;
              r_baud_start <= 1'b1;
              r_bit_idx    <= '0;
              r_fe_pend    <= 1'b0;
              r_pe_pend    <= 1'b0;
            end else begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end
        end
        S_DATA: begin
          if (w_tick) begin
            r_shift   <= {r_rx_s, r_shift[DATA_BITS-1:1]};
            r_bit_idx <= r_bit_idx + 4'd1;
            if (w_last_data) begin
              r_state    <= (PARITY_EN != 0) ? S_PARITY : S_STOP;
              r_stop_idx <= '0;
            end
          end
        end
        S_PARITY: begin
          if (w_tick) begin
            r_pe_pend <= w_par_calc;
            r_state   <= S_STOP;
          end
        end
        S_STOP: begin
          if (w_tick) begin
            if (!r_rx_s) begin
              r_fe_pend <= 1'b1;
            end
            r_stop_idx <= r_stop_idx + 2'd1;
            if (w_last_stop) begin
              r_state      <= S_DONE;
              r_baud_start <= 1'b0;
            end
          end
        end
        S_DONE: begin
          r_valid <= 1'b1;
          r_data  <= r_shift;
          r_fe    <= r_fe_pend;
          r_pe    <= r_pe_pend;
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state      <= S_IDLE;
          r_busy       <= 1'b0;
          r_baud_start <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_frame.sv
// tb_uart_rx_frame: four framer configurations driven with directed and
// random frames; expectations derived from the bits put on the line.
`timescale 1ns/1ps
module tb_uart_rx_frame;

  localparam int N   = 4;
  localparam int BIT = 10;
  // u0: no parity/1 stop, u1: even/1 stop, u2: odd/2 stop, u3: none/2 stop
  localparam logic [N-1:0] PE_V = 4'b0110;
  localparam logic [N-1:0] PO_V = 4'b0100;
  localparam logic [N-1:0] S2_V = 4'b1100;

  logic         clk = 1'b0;
  logic         areset_n = 1'b0;
  logic [31:0]  divisor = 32'd9;
  logic [N-1:0] rx = '1;
  logic [N-1:0] w_tick;
  logic [N-1:0] w_bs;
  logic [N-1:0] w_dv;
  logic [N-1:0] w_fe;
  logic [N-1:0] w_pe;
  logic [N-1:0] w_busy;
  logic [7:0]   w_data [N];

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : gen_u
    logic [31:0] cnt;

    uart_rx_frame #(
      .DATA_BITS  (8),
      .PARITY_EN  (int'(PE_V[g])),
      .PARITY_ODD (int'(PO_V[g])),
      .STOP_BITS  (S2_V[g] ? 2 : 1)
    ) u_dut (
      .clk        (clk),
      .areset_n   (areset_n),
      .rx         (rx[g]),
      .divisor    (divisor),
      .baud_tick  (w_tick[g]),
      .baud_start (w_bs[g]),
      .data       (w_data[g]),
      .data_valid (w_dv[g]),
      .frame_err  (w_fe[g]),
      .parity_err (w_pe[g]),
      .busy       (w_busy[g])
    );

    // baud generator: counter from 0 while enabled, tick every divisor+1
    always @(posedge clk or negedge areset_n) begin
      if (!areset_n) cnt <= '0;
      else if (!w_bs[g] || cnt == divisor) cnt <= '0;
      else cnt <= cnt + 32'd1;
    end
    assign w_tick[g] = w_bs[g] && (cnt == divisor);
  end

  logic [7:0]   ev_d  [N][32];
  logic         ev_fe [N][32];
  logic         ev_pe [N][32];
  int           nev      [N] = '{default: 0};
  int           bs_cyc   [N] = '{default: 0};
  int           busy_cyc [N] = '{default: 0};
  int           dv_long  [N] = '{default: 0};
  logic [N-1:0] dv_prev = '0;

  // log every valid strobe and count activity cycles per unit
  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (w_dv[i]) begin
        ev_d[i][nev[i] % 32]  <= w_data[i];
        ev_fe[i][nev[i] % 32] <= w_fe[i];
        ev_pe[i][nev[i] % 32] <= w_pe[i];
        nev[i] <= nev[i] + 1;
      end
      if (w_bs[i]) bs_cyc[i] <= bs_cyc[i] + 1;
      if (w_busy[i]) busy_cyc[i] <= busy_cyc[i] + 1;
      if (w_dv[i] && dv_prev[i]) dv_long[i] <= dv_long[i] + 1;
    end
    dv_prev <= w_dv;
  end

  typedef struct {
    int         u;
    logic [7:0] d;
    logic       fe;
    logic       pe;
  } exp_t;

  exp_t expq[$];
  int   rd [N] = '{default: 0};
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // build one frame from the line rules, queue its expected result, drive it
  task automatic send(input int u, input logic [7:0] d,
                      input bit pflip, input bit slow);
    bit   q[$];
    bit   p;
    bit   b;
    int   ns;
    exp_t e;
    ns = S2_V[u] ? 2 : 1;
    q.push_back(1'b0);
    for (int i = 0; i < 8; i++) q.push_back(d[i]);
    e.pe = 1'b0;
    if (PE_V[u]) begin
      p = (($countones(d) % 2) == 1) ^ PO_V[u] ^ pflip;
      q.push_back(p);
      e.pe = ((($countones(d) + int'(p)) % 2) != int'(PO_V[u]));
    end
    e.fe = 1'b0;
    for (int s = 0; s < ns; s++) begin
      b = !(slow && s == ns - 1);
      q.push_back(b);
      if (!b) e.fe = 1'b1;
    end
    e.u = u;
    e.d = d;
    expq.push_back(e);
    foreach (q[k]) begin
      rx[u] = q[k];
      idle(BIT);
    end
    rx[u] = 1'b1;
  endtask

  // match every queued expectation against logged strobes, in order
  task automatic drain();
    exp_t e;
    int   t;
    while (expq.size() > 0) begin
      e = expq.pop_front();
      t = 0;
      while (nev[e.u] <= rd[e.u] && t < 400) begin
        @(negedge clk);
        t++;
      end
      chk($sformatf("u%0d valid_seen", e.u), 32'(nev[e.u] > rd[e.u]), 1);
      if (nev[e.u] > rd[e.u]) begin
        chk($sformatf("u%0d data", e.u), ev_d[e.u][rd[e.u] % 32], e.d);
        chk($sformatf("u%0d frame_err", e.u), ev_fe[e.u][rd[e.u] % 32], e.fe);
        chk($sformatf("u%0d parity_err", e.u), ev_pe[e.u][rd[e.u] % 32], e.pe);
        rd[e.u]++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  int         snap;
  int         snap2;
  int         snap3;
  int         uu;
  bit         sl;
  logic [7:0] rd8;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("u%0d rst busy", i), w_busy[i], 0);
      chk($sformatf("u%0d rst baud_start", i), w_bs[i], 0);
      chk($sformatf("u%0d rst valid", i), w_dv[i], 0);
      chk($sformatf("u%0d rst data", i), w_data[i], 0);
      chk($sformatf("u%0d rst ferr", i), w_fe[i], 0);
      chk($sformatf("u%0d rst perr", i), w_pe[i], 0);
    end
    @(posedge clk);
    #1;
    areset_n = 1'b1;
    idle(5);

    // plain 8N1 frame
    snap = bs_cyc[0];
    send(0, 8'hA5, 1'b0, 1'b0);
    idle(5);
    drain();
    chk("t1 baud_start span", 32'((bs_cyc[0] - snap) inside {[85:95]}), 1);
    chk("t1 baud_start low", w_bs[0], 0);
    chk("t1 busy low", w_busy[0], 0);

    // 3-clock glitch must be rejected at mid-bit
    snap  = nev[0];
    snap2 = bs_cyc[0];
    snap3 = busy_cyc[0];
    rx[0] = 1'b0;
    idle(3);
    rx[0] = 1'b1;
    idle(20);
    chk("t2 start_chk seen", 32'((busy_cyc[0] - snap3) inside {[3:7]}), 1);
    chk("t2 no baud_start", bs_cyc[0] - snap2, 0);
    chk("t2 no valid", nev[0] - snap, 0);
    chk("t2 idle", w_busy[0], 0);
    chk("t2 data held", w_data[0], 8'hA5);

    // low stop bit, then a held-low break, then a clean frame
    send(0, 8'h3C, 1'b0, 1'b1);
    rx[0] = 1'b0;
    snap  = busy_cyc[0];
    idle(50);
    chk("t3 break no busy", busy_cyc[0] - snap, 0);
    rx[0] = 1'b1;
    idle(20);
    send(0, 8'h11, 1'b0, 1'b0);
    idle(5);
    drain();

    // even then odd parity, good and flipped parity bit
    send(1, 8'h03, 1'b0, 1'b0);
    idle(5);
    send(1, 8'h03, 1'b1, 1'b0);
    idle(5);
    send(2, 8'h03, 1'b0, 1'b0);
    idle(5);
    send(2, 8'h03, 1'b1, 1'b0);
    idle(5);
    drain();

    // reset during the 4th data bit of 0xC3
    rx[0] = 1'b0;
    idle(BIT);
    rd8 = 8'hC3;
    for (int i = 0; i < 3; i++) begin
      rx[0] = rd8[i];
      idle(BIT);
    end
    rx[0] = rd8[3];
    idle(5);
    areset_n = 1'b0;
    #1;
    chk("t5 rst busy", w_busy[0], 0);
    chk("t5 rst baud_start", w_bs[0], 0);
    chk("t5 rst data", w_data[0], 0);
    chk("t5 rst valid", w_dv[0], 0);
    rx[0] = 1'b1;
    idle(3);
    areset_n = 1'b1;
    idle(20);
    send(0, 8'h5A, 1'b0, 1'b0);
    idle(5);
    drain();

    // zero-gap frames with two stop bits, then a short stop
    send(3, 8'h81, 1'b0, 1'b0);
    send(3, 8'h7E, 1'b0, 1'b0);
    idle(5);
    drain();
    send(3, 8'h55, 1'b0, 1'b1);
    idle(20);
    drain();

    // randomized frames across all units
    for (int k = 0; k < 16; k++) begin
      uu  = $urandom_range(0, N - 1);
      rd8 = 8'($urandom);
      sl  = ($urandom_range(0, 3) == 0);
      send(uu, rd8, 1'($urandom_range(0, 1)), sl);
      idle(sl ? 12 : $urandom_range(0, 15));
      drain();
    end

    idle(30);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("u%0d valid count", i), nev[i], rd[i]);
      chk($sformatf("u%0d valid width", i), dv_long[i], 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
